// File: rtl/decode_stage_if.sv
// Handshake and decoded-bundle bus between fetch, the decode stage and execute.
// The master side drives the instruction and flow control; the decode stage is the slave.
interface decode_stage_if #(
  parameter int IMM_W = 16
);
  logic             flush;
  logic             in_valid;
  logic [15:0]      in_inst;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       opcode;
  logic [2:0]       func;
  logic [2:0]       rd;
  logic [2:0]       rs1;
  logic [2:0]       rs2;
  logic [IMM_W-1:0] imm;
  logic             reg_we;
  logic             illegal;
  logic             stall;

  modport master (
    output flush, in_valid, in_inst, out_ready,
    input  in_ready, out_valid, opcode, func, rd, rs1, rs2, imm, reg_we, illegal, stall
  );

  modport slave (
    input  flush, in_valid, in_inst, out_ready,
    output in_ready, out_valid, opcode, func, rd, rs1, rs2, imm, reg_we, illegal, stall
  );
endinterface

// File: rtl/decode_stage.sv
// Octa16 decode stage: one-entry registered bundle with valid/ready flow control,
// illegal-encoding detection, flush and an optional one-bubble load-use interlock.
module decode_stage #(
  parameter int IMM_W          = 16,
  parameter bit LOAD_USE_STALL = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  decode_stage_if.slave bus
);
  logic [2:0] f_op, f_f, f_d, f_a, f_b;
  logic       f_s;

  assign f_op = bus.in_inst[2:0];
  assign f_f  = bus.in_inst[5:3];
  assign f_d  = bus.in_inst[8:6];
  assign f_a  = bus.in_inst[11:9];
  assign f_b  = bus.in_inst[14:12];
  assign f_s  = bus.in_inst[15];

  logic [2:0]       func_next, rd_next, rs1_next, rs2_next;
  logic [7:0]       imm8;
  logic             imm_sext;
  logic [IMM_W-1:0] imm_next;
  logic             we_next, ill_next, use_rs1, use_rs2;

  always_comb begin
    func_next = 3'd0;
    rd_next   = 3'd0;
    rs1_next  = 3'd0;
    rs2_next  = 3'd0;
    imm8      = 8'd0;
    imm_sext  = 1'b0;
    we_next   = 1'b0;
    ill_next  = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    case (f_op)
      3'b000: begin
        rs1_next = f_a; rs2_next = f_b; rd_next = f_d; func_next = f_f;
        we_next = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      3'b001: begin
        rs1_next = f_a; rd_next = f_d; func_next = f_f;
        imm8 = {{4{f_s}}, f_s, f_b}; imm_sext = 1'b1;
        we_next = 1'b1; use_rs1 = 1'b1;
      end
      3'b010: begin
        rs1_next = f_a; rd_next = f_d;
        imm8 = {f_s, f_s, f_b, f_f}; imm_sext = 1'b1;
        we_next = 1'b1; use_rs1 = 1'b1;
      end
      3'b011: begin
        rs1_next = f_a; rs2_next = f_d;
        imm8 = {f_s, f_s, f_b, f_f}; imm_sext = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      3'b100: begin
        rs1_next = f_a; rs2_next = f_b; func_next = f_f;
        imm8 = {{4{f_s}}, f_s, f_d}; imm_sext = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      3'b101: begin
        if (f_f == 3'b000) begin
          rd_next = f_d; imm8 = {1'b0, bus.in_inst[15:9]}; we_next = 1'b1;
        end else if (f_f == 3'b100) begin
          rd_next = f_d; rs1_next = f_a; imm8 = {bus.in_inst[15:12], 4'b0000};
          we_next = 1'b1; use_rs1 = 1'b1;
        end else begin
          ill_next = 1'b1; func_next = f_f;
        end
      end
      3'b110: begin
        if (f_f == 3'b001) begin
          rd_next = f_d; imm8 = {bus.in_inst[15], bus.in_inst[15:9]}; imm_sext = 1'b1;
          we_next = 1'b1;
        end else if (f_f == 3'b000) begin
          rd_next = f_d; rs1_next = f_a; imm8 = {bus.in_inst[15:12], 4'b0000};
          we_next = 1'b1; use_rs1 = 1'b1;
        end else begin
          ill_next = 1'b1; func_next = f_f;
        end
      end
      default: begin
        ill_next = 1'b1; func_next = f_f;
      end
    endcase
  end

  // Immediates are formed at 8 bits, then widened according to their signedness.
  generate
    if (IMM_W > 8) begin : g_imm_wide
      assign imm_next = {{(IMM_W-8){imm_sext & imm8[7]}}, imm8};
    end else begin : g_imm_narrow
      assign imm_next = imm8;
    end
  endgenerate

  logic out_valid_reg;
  logic stall_int;
  logic accept;

  assign bus.in_ready = (!out_valid_reg || bus.out_ready) && !stall_int && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.stall    = stall_int;

  generate
    if (LOAD_USE_STALL) begin : g_hazard
      logic       hz_pend_reg;
      logic [2:0] hz_rd_reg;
      logic       is_load;

      assign is_load   = (f_op == 3'b010);
      assign stall_int = hz_pend_reg && bus.in_valid && !bus.flush &&
                         ((use_rs1 && rs1_next == hz_rd_reg) ||
                          (use_rs2 && rs2_next == hz_rd_reg));

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          hz_pend_reg <= 1'b0;
          hz_rd_reg   <= 3'd0;
        end else if (bus.flush) begin
          hz_pend_reg <= 1'b0;
        end else if (accept) begin
          hz_pend_reg <= is_load;
          if (is_load) hz_rd_reg <= rd_next;
        end else if (stall_int) begin
          hz_pend_reg <= 1'b0;
        end
      end
    end else begin : g_no_hazard
      assign stall_int = 1'b0;
    end
  endgenerate

  logic [2:0]       opcode_reg, func_reg, rd_reg, rs1_reg, rs2_reg;
  logic [IMM_W-1:0] imm_reg;
  logic             we_reg, ill_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      opcode_reg    <= 3'd0;
      func_reg      <= 3'd0;
      rd_reg        <= 3'd0;
      rs1_reg       <= 3'd0;
      rs2_reg       <= 3'd0;
      imm_reg       <= '0;
      we_reg        <= 1'b0;
      ill_reg       <= 1'b0;
    end else if (bus.flush) begin
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      opcode_reg    <= f_op;
      func_reg      <= func_next;
      rd_reg        <= rd_next;
      rs1_reg       <= rs1_next;
      rs2_reg       <= rs2_next;
      imm_reg       <= imm_next;
      we_reg        <= we_next;
      ill_reg       <= ill_next;
    end else if (out_valid_reg && bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.opcode    = opcode_reg;
  assign bus.func      = func_reg;
  assign bus.rd        = rd_reg;
  assign bus.rs1       = rs1_reg;
  assign bus.rs2       = rs2_reg;
  assign bus.imm       = imm_reg;
  assign bus.reg_we    = we_reg;
  assign bus.illegal   = ill_reg;
endmodule

// File: tb/tb_decode_stage.sv
// Directed plus randomized bench for decode_stage, checked against a field-level
// reference decoder and a transaction-level model of the handshake and interlock.
module tb_decode_stage;
  localparam int IMM_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decode_stage_if #(.IMM_W(IMM_W)) bus ();

  decode_stage #(.IMM_W(IMM_W), .LOAD_USE_STALL(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int op, func, rd, rs1, rs2, imm;
    bit we, ill, use1, use2;
  } dec_t;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit   m_valid;
  dec_t m_out;
  bit   m_hz;
  int   m_hz_rd;
  bit   obs_stall, obs_ready;

  function automatic int sx(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  function automatic dec_t ref_decode(input logic [15:0] w);
    dec_t r;
    int   word, f, d, a, b, s;
    word = int'(w);
    f = (word >> 3) & 7;  d = (word >> 6) & 7;
    a = (word >> 9) & 7;  b = (word >> 12) & 7;  s = (word >> 15) & 1;
    r = '{op: word & 7, func: 0, rd: 0, rs1: 0, rs2: 0, imm: 0,
          we: 1'b0, ill: 1'b0, use1: 1'b0, use2: 1'b0};
    case (r.op)
      0: begin r.rs1 = a; r.rs2 = b; r.rd = d; r.func = f; r.we = 1; r.use1 = 1; r.use2 = 1; end
      1: begin r.rs1 = a; r.rd = d; r.func = f; r.imm = sx(s * 8 + b, 4); r.we = 1; r.use1 = 1; end
      2: begin r.rs1 = a; r.rd = d; r.imm = sx(s * 64 + b * 8 + f, 7); r.we = 1; r.use1 = 1; end
      3: begin r.rs1 = a; r.rs2 = d; r.imm = sx(s * 64 + b * 8 + f, 7); r.use1 = 1; r.use2 = 1; end
      4: begin r.rs1 = a; r.rs2 = b; r.func = f; r.imm = sx(s * 8 + d, 4); r.use1 = 1; r.use2 = 1; end
      5: begin
        if (f == 0)      begin r.rd = d; r.imm = (word >> 9) & 127; r.we = 1; end
        else if (f == 4) begin r.rd = d; r.rs1 = a; r.imm = ((word >> 12) & 15) * 16; r.we = 1; r.use1 = 1; end
        else             begin r.ill = 1; r.func = f; end
      end
      6: begin
        if (f == 1)      begin r.rd = d; r.imm = sx((word >> 9) & 127, 7); r.we = 1; end
        else if (f == 0) begin r.rd = d; r.rs1 = a; r.imm = ((word >> 12) & 15) * 16; r.we = 1; r.use1 = 1; end
        else             begin r.ill = 1; r.func = f; end
      end
      default: begin r.ill = 1; r.func = f; end
    endcase
    r.imm = r.imm & ((1 << IMM_W) - 1);
    return r;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_out   = '{op: 0, func: 0, rd: 0, rs1: 0, rs2: 0, imm: 0,
                we: 1'b0, ill: 1'b0, use1: 1'b0, use2: 1'b0};
    m_hz    = 0;
    m_hz_rd = 0;
  endtask

  // One clock cycle: drive, check combinational outputs, clock, check registered outputs.
  task automatic step(input bit r, input bit v, input logic [15:0] w, input bit ordy, input bit fl);
    dec_t d;
    bit   m_stall, m_ready;
    rst_n         = r;
    bus.in_valid  = v;
    bus.in_inst   = w;
    bus.out_ready = ordy;
    bus.flush     = fl;
    d = ref_decode(w);
    @(negedge clk);
    m_stall = m_hz && v && !fl &&
              ((d.use1 && d.rs1 == m_hz_rd) || (d.use2 && d.rs2 == m_hz_rd));
    m_ready = (!m_valid || ordy) && !m_stall && !fl;
    obs_stall = bus.stall;
    obs_ready = bus.in_ready;
    if (r) begin
      check("stall", int'(bus.stall), int'(m_stall));
      check("in_ready", int'(bus.in_ready), int'(m_ready));
    end
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else if (fl) begin
      m_valid = 0;
      m_hz    = 0;
    end else if (v && m_ready) begin
      m_valid = 1;
      m_out   = d;
      m_hz    = (d.op == 2);
      if (d.op == 2) m_hz_rd = d.rd;
    end else begin
      if (m_valid && ordy) m_valid = 0;
      if (m_stall) m_hz = 0;
    end
    #1;
    check("out_valid", int'(bus.out_valid), int'(m_valid));
    check("opcode", int'(bus.opcode), m_out.op);
    if (!m_out.ill) check("func", int'(bus.func), m_out.func);
    check("rd", int'(bus.rd), m_out.rd);
    check("rs1", int'(bus.rs1), m_out.rs1);
    check("rs2", int'(bus.rs2), m_out.rs2);
    check("imm", int'(bus.imm), m_out.imm);
    check("reg_we", int'(bus.reg_we), int'(m_out.we));
    check("illegal", int'(bus.illegal), int'(m_out.ill));
    $display("step rst_n=%0b v=%0b inst=%04h ordy=%0b flush=%0b -> out_valid=%0b rd=%0d imm=%04h stall=%0b",
             r, v, w, ordy, fl, bus.out_valid, bus.rd, bus.imm, obs_stall);
  endtask

  initial begin
    logic [15:0] w;
    model_reset();
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.in_inst = 16'h0; bus.out_ready = 1'b0; bus.flush = 1'b0;

    // Reset for two cycles, then look at the idle state
    step(0, 1, 16'h22C0, 1, 0);
    step(0, 1, 16'h22C0, 1, 0);
    rst_n = 1'b1; bus.in_valid = 1'b0;
    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_imm", int'(bus.imm), 0);
    check("rst_illegal", int'(bus.illegal), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);

    // Back-to-back R then I
    step(1, 1, 16'h22C0, 1, 0);
    check("tp_r_rd", int'(bus.rd), 3);
    check("tp_r_rs1", int'(bus.rs1), 1);
    check("tp_r_rs2", int'(bus.rs2), 2);
    check("tp_r_we", int'(bus.reg_we), 1);
    step(1, 1, 16'hE281, 1, 0);
    check("tp_i_rs1", int'(bus.rs1), 1);
    check("tp_i_rd", int'(bus.rd), 2);
    check("tp_i_imm", int'(bus.imm), 16'hFFFE);

    // Load-use: one bubble, then the dependent instruction goes in
    step(1, 1, 16'h02E2, 1, 0);
    check("tp_ld_rd", int'(bus.rd), 3);
    check("tp_ld_imm", int'(bus.imm), 4);
    step(1, 1, 16'h2700, 1, 0);
    check("tp_lu_stall", int'(obs_stall), 1);
    check("tp_lu_ready", int'(obs_ready), 0);
    step(1, 1, 16'h2700, 1, 0);
    check("tp_lu_ready2", int'(obs_ready), 1);
    check("tp_lu_rs1", int'(bus.rs1), 3);

    // JAL, then an illegal opcode
    step(1, 1, 16'hFFC5, 1, 0);
    check("tp_jal_rd", int'(bus.rd), 7);
    check("tp_jal_imm", int'(bus.imm), 16'h007F);
    check("tp_jal_we", int'(bus.reg_we), 1);
    step(1, 1, 16'h0007, 1, 0);
    check("tp_ill", int'(bus.illegal), 1);
    check("tp_ill_we", int'(bus.reg_we), 0);
    check("tp_ill_imm", int'(bus.imm), 0);

    // Backpressure for three cycles
    step(1, 1, 16'h22C0, 1, 0);
    repeat (3) begin
      step(1, 1, 16'hE281, 0, 0);
      check("tp_bp_ready", int'(obs_ready), 0);
      check("tp_bp_hold_rd", int'(bus.rd), 3);
    end
    step(1, 1, 16'hE281, 1, 0);
    check("tp_bp_release_rd", int'(bus.rd), 2);
    step(1, 0, 16'h0000, 1, 0);
    check("tp_bp_drained", int'(bus.out_valid), 0);

    // Flush with a bundle held and a load hazard pending
    step(1, 1, 16'h02E2, 0, 0);
    step(1, 0, 16'h0000, 0, 1);
    check("tp_fl_valid", int'(bus.out_valid), 0);
    step(1, 1, 16'h2700, 1, 0);
    check("tp_fl_nostall", int'(obs_stall), 0);
    check("tp_fl_accept", int'(bus.rs1), 3);

    // Mid-stream reset discards the held bundle
    step(1, 1, 16'h02E2, 0, 0);
    step(0, 1, 16'h2700, 0, 0);
    check("tp_midrst_valid", int'(bus.out_valid), 0);

    // Randomized traffic, biased towards loads so the interlock is exercised
    for (int n = 0; n < 500; n++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 2) == 0) w[2:0] = 3'b010;
      step($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 8, w,
           $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
